// File: rtl/alu_bist_pkg.sv
// Shared types and the directed vector set for the ALU built-in self-test.
package alu_bist_pkg;

  localparam int unsigned VEC_W     = 20;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned ROM_DEPTH = 8;
  localparam int unsigned ERR_W     = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic [VEC_W-1:0] exp_result;
    logic             exp_z;
  } bist_vec_t;

  // One vector per opcode, so a fault on a single opcode hits exactly one entry.
  localparam bist_vec_t VEC_ROM [ROM_DEPTH] = '{
    '{a: 20'h80000, b: 20'h80000, op: OP_ADD, exp_result: 20'h00000, exp_z: 1'b1},
    '{a: 20'hAAAAA, b: 20'h55555, op: OP_SUB, exp_result: 20'h55555, exp_z: 1'b0},
    '{a: 20'h00006, b: 20'h00002, op: OP_MUL, exp_result: 20'h0000C, exp_z: 1'b0},
    '{a: 20'h00006, b: 20'h00004, op: OP_DIV, exp_result: 20'h00001, exp_z: 1'b0},
    '{a: 20'hAAAAA, b: 20'h55555, op: OP_AND, exp_result: 20'h00000, exp_z: 1'b1},
    '{a: 20'hAAAAA, b: 20'h55555, op: OP_OR,  exp_result: 20'hFFFFF, exp_z: 1'b0},
    '{a: 20'h00003, b: 20'h00004, op: OP_SHL, exp_result: 20'h00030, exp_z: 1'b0},
    '{a: 20'h00020, b: 20'h00002, op: OP_SHR, exp_result: 20'h00008, exp_z: 1'b0}
  };

endpackage

// File: rtl/alu_bist_rom.sv
// Combinational lookup of one directed test vector by index.
module alu_bist_rom
  import alu_bist_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output bist_vec_t        vec_c
);

  assign vec_c = VEC_ROM[index];

endmodule

// File: rtl/alu_bist.sv
// ALU self-test initiator: drives the vector set, samples Result/Z after settling,
// and reports pass, error count and the first failing vector.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned N             = 20,
  parameter int unsigned NUM_VEC       = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_index,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [OP_W-1:0]  alu_opcode,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_z
);

  localparam int unsigned     CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  bist_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     exp_result_q;
  logic             exp_z_q;

  logic [IDX_W-1:0] load_idx_c;
  bist_vec_t        rom_vec_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_next_c;

  // The ROM is only consulted when entering APPLY: index 0 from IDLE, idx+1 from CHECK.
  assign load_idx_c = (state == ST_CHECK) ? idx + IDX_W'(1) : '0;
  assign mismatch_c = (alu_result != exp_result_q) || (alu_z != exp_z_q);
  assign err_next_c = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

  alu_bist_rom u_rom (
    .index (load_idx_c),
    .vec_c (rom_vec_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      exp_result_q <= '0;
      exp_z_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_valid   <= 1'b0;
      fail_index   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= ST_APPLY;
            idx          <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_index   <= '0;
            alu_a        <= N'(rom_vec_c.a);
            alu_b        <= N'(rom_vec_c.b);
            alu_opcode   <= rom_vec_c.op;
            exp_result_q <= N'(rom_vec_c.exp_result);
            exp_z_q      <= rom_vec_c.exp_z;
          end
        end
        ST_APPLY: begin
          state <= ST_WAIT;
          cnt   <= CNT_W'(SETTLE_CYCLES - 1);
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_CHECK;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_CHECK: begin
          if (mismatch_c) begin
            err_count <= err_next_c;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_index <= idx;
            end
          end
          // Last vector: pass must account for a mismatch landing on this same edge.
          if (idx == LAST_IDX) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (err_count == '0) && !mismatch_c;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
          end else begin
            state        <= ST_APPLY;
            idx          <= load_idx_c;
            alu_a        <= N'(rom_vec_c.a);
            alu_b        <= N'(rom_vec_c.b);
            alu_opcode   <= rom_vec_c.op;
            exp_result_q <= N'(rom_vec_c.exp_result);
            exp_z_q      <= rom_vec_c.exp_z;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with fault injection, run-level reference model.
module tb_alu_bist;

  localparam int unsigned N  = 20;
  localparam int unsigned NV = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1;
  logic busy0, done0, pass0, fv0, z0;
  logic busy1, done1, pass1, fv1, z1;
  logic [3:0] err0, err1;
  logic [2:0] fi0, fi1, op0, op1;
  logic [N-1:0] a0, b0, res0, a1, b1, res1;

  alu_bist #(.N(N), .NUM_VEC(NV), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_index(fi0), .alu_a(a0), .alu_b(b0),
    .alu_opcode(op0), .alu_result(res0), .alu_z(z0));

  alu_bist #(.N(N), .NUM_VEC(NV), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_index(fi1), .alu_a(a1), .alu_b(b1),
    .alu_opcode(op1), .alu_result(res1), .alu_z(z1));

  // Fault injection: XOR pattern on Result for opcodes in fmask, optional Z stuck-at-0.
  logic [7:0]   fmask;
  logic [N-1:0] xpat;
  logic         stuckz;

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == '0) ? '0 : a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  always_comb begin
    res0 = alu_f(a0, b0, op0) ^ (fmask[op0] ? xpat : '0);
    z0   = stuckz ? 1'b0 : (alu_f(a0, b0, op0) == '0);
    res1 = alu_f(a1, b1, op1) ^ (fmask[op1] ? xpat : '0);
    z1   = stuckz ? 1'b0 : (alu_f(a1, b1, op1) == '0);
  end

  // Observation mux: which DUT the current step exercises.
  bit use3;
  logic o_busy, o_done, o_pass, o_fv;
  logic [3:0] o_err;
  logic [2:0] o_fi, o_op;
  logic [N-1:0] o_a, o_b;
  assign o_busy = use3 ? busy1 : busy0;
  assign o_done = use3 ? done1 : done0;
  assign o_pass = use3 ? pass1 : pass0;
  assign o_fv   = use3 ? fv1 : fv0;
  assign o_err  = use3 ? err1 : err0;
  assign o_fi   = use3 ? fi1 : fi0;
  assign o_op   = use3 ? op1 : op0;
  assign o_a    = use3 ? a1 : a0;
  assign o_b    = use3 ? b1 : b0;

  // Directed vector set as written in the block description.
  logic [N-1:0] va [NV];
  logic [N-1:0] vb [NV];
  logic [N-1:0] ve [NV];
  logic [2:0]   vo [NV];
  logic         vz [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit v);
    if (use3) start1 = v;
    else      start0 = v;
  endtask

  // Run-level expectation: which vectors the (possibly faulty) ALU gets wrong.
  task automatic model(output int ecnt, output int fidx, output bit fval);
    ecnt = 0; fidx = 0; fval = 1'b0;
    for (int i = 0; i < int'(NV); i++) begin
      logic [N-1:0] r;
      logic         z;
      r = alu_f(va[i], vb[i], vo[i]) ^ (fmask[vo[i]] ? xpat : '0);
      z = stuckz ? 1'b0 : (alu_f(va[i], vb[i], vo[i]) == '0);
      if (r != ve[i] || z != vz[i]) begin
        if (ecnt < 15) ecnt++;
        if (!fval) begin fval = 1'b1; fidx = i; end
      end
    end
  endtask

  task automatic run(input string name, input int settle, input bit glitch);
    int p, last, first_done, ndone, ecnt, fidx;
    bit fval, ops_ok, busy_ok;
    p = 2 + settle;
    last = int'(NV) * p + 1;
    first_done = -1; ndone = 0; ops_ok = 1'b1; busy_ok = 1'b1;
    model(ecnt, fidx, fval);
    pulse_start(1'b1);
    tick();
    pulse_start(1'b0);
    for (int c = 1; c <= last + 5; c++) begin
      if (o_done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (o_busy !== (c < last)) busy_ok = 1'b0;
      if (c < last) begin
        int vi;
        vi = (c - 1) / p;
        if ({o_a, o_b, o_op} !== {va[vi], vb[vi], vo[vi]}) ops_ok = 1'b0;
      end else if ({o_a, o_b, o_op} !== '0) ops_ok = 1'b0;
      if (glitch && (c == 1 + 2 * p || c == last)) pulse_start(1'b1);
      tick();
      pulse_start(1'b0);
    end
    chk({name, ":done_cycle"}, 32'(first_done), 32'(last));
    chk({name, ":done_pulses"}, 32'(ndone), 32'd1);
    chk({name, ":busy_window"}, 32'(busy_ok), 32'd1);
    chk({name, ":operands"}, 32'(ops_ok), 32'd1);
    chk({name, ":pass"}, 32'(o_pass), 32'(ecnt == 0));
    chk({name, ":err_count"}, 32'(o_err), 32'(ecnt));
    chk({name, ":fail_valid"}, 32'(o_fv), 32'(fval));
    chk({name, ":fail_index"}, 32'(o_fi), 32'(fidx));
  endtask

  initial begin
    va = '{20'h80000, 20'hAAAAA, 20'h00006, 20'h00006, 20'hAAAAA, 20'hAAAAA, 20'h00003, 20'h00020};
    vb = '{20'h80000, 20'h55555, 20'h00002, 20'h00004, 20'h55555, 20'h55555, 20'h00004, 20'h00002};
    vo = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    ve = '{20'h00000, 20'h55555, 20'h0000C, 20'h00001, 20'h00000, 20'hFFFFF, 20'h00030, 20'h00008};
    vz = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    fmask = '0; xpat = '0; stuckz = 1'b0;
    start0 = 1'b0; start1 = 1'b0; use3 = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset:outs0", 32'({busy0, done0, pass0, fv0, err0, fi0}), 32'd0);
    chk("reset:drive0", 32'({a0, b0, op0} != '0), 32'd0);
    chk("reset:outs1", 32'({busy1, done1, pass1, fv1, err1, fi1}), 32'd0);
    tick();

    run("clean", 1, 1'b0);

    fmask = 8'b0000_1000; xpat = 20'h00001;
    run("div_bit0", 1, 1'b0);
    fmask = '0; xpat = '0;

    stuckz = 1'b1;
    run("z_stuck0", 1, 1'b0);

    stuckz = 1'b0;
    run("start_glitch", 1, 1'b1);

    // Reset during vector 4 with a Z fault so the pre-reset state is non-zero.
    stuckz = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c < 1 + 4 * 3 + 1; c++) tick();
    chk("midrun:err_before", 32'(err0), 32'd1);
    chk("midrun:busy_before", 32'(busy0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun:outs", 32'({busy0, done0, pass0, fv0, err0, fi0}), 32'd0);
    chk("midrun:drive", 32'({a0, b0, op0} != '0), 32'd0);
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 30; c++) begin
        if (done0 === 1'b1) nd++;
        tick();
      end
      chk("midrun:no_done", 32'(nd), 32'd0);
    end
    stuckz = 1'b0;
    run("after_rst", 1, 1'b0);

    use3 = 1'b1;
    run("settle3", 3, 1'b0);

    for (int r = 0; r < 8; r++) begin
      use3   = 1'($urandom_range(0, 1));
      fmask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      xpat   = 20'($urandom_range(1, 20'hFFFFF));
      stuckz = ($urandom_range(0, 3) == 0);
      run($sformatf("rand%0d", r), use3 ? 3 : 1, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Hardware built-in self-test engine for the unicycle datapath ALU. It acts as the initiator on the ALU's operand/opcode interface. On `start` it drives a fixed directed vector set into the combinational ALU, waits for settling, and compares `Result`/`Z` against stored expectations. It then reports pass/fail, an error count and the first failing vector. It sits beside the ALU and is muxed onto the ALU inputs during test.

## Interface
- `N`, 20: datapath width; the built-in vector set is defined for N=20.
- `NUM_VEC`, 8: number of vectors executed (1..8).
- `SETTLE_CYCLES`, 1: wait cycles between driving a vector and sampling the ALU (≥1).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a test run; sampled only in IDLE.
- `busy`  out  1  high from APPLY through CHECK of the last vector.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the completed run had zero mismatches.
- `err_count`  out  4  number of mismatching vectors in the last run.
- `fail_valid`  out  1  at least one mismatch captured.
- `fail_index`  out  3  index of the first mismatching vector.
- `alu_a`, `alu_b`  out  N  ALU operands.
- `alu_opcode`  out  3  ALU opcode.
- `alu_result`  in  N  ALU result.
- `alu_z`  in  1  ALU zero flag.

## Operation
- Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 shl, 111 shr.
- Vector ROM (index: A, B, op → expected Result, Z):
  - 0: 80000, 80000, add → 00000, 1
  - 1: AAAAA, 55555, sub → 55555, 0
  - 2: 00006, 00002, mul → 0000C, 0
  - 3: 00006, 00004, div → 00001, 0
  - 4: AAAAA, 55555, and → 00000, 1
  - 5: AAAAA, 55555, or → FFFFF, 0
  - 6: 00003, 00004, shl → 00030, 0
  - 7: 00020, 00002, shr → 00008, 0
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE → APPLY when `start`=1. On this transition, clear `err_count`, `fail_valid`, `fail_index` and `pass`, and set vector index i=0.
  - APPLY → WAIT.
  - WAIT stays for SETTLE_CYCLES cycles (down-counter), then → CHECK.
  - CHECK → APPLY with i+1 if i<NUM_VEC-1, else → DONE.
  - DONE → IDLE unconditionally.
- Mismatch in CHECK: `alu_result`≠expected OR `alu_z`≠expected Z. Increment `err_count` (saturate at 15). If `fail_valid`=0, set `fail_valid`=1 and `fail_index`=i.
- In DONE: `done`=1 and `pass`=(err_count==0). Result outputs hold until the next accepted `start`.
- `alu_a`/`alu_b`/`alu_opcode` are registered. They present vector i from APPLY through CHECK and are 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, all outputs 0 (`pass`=0, `done`=0, `busy`=0, ALU drive 0).
- Per vector: 2+SETTLE_CYCLES cycles. ALU operands become valid the cycle after APPLY is entered and stay stable ≥SETTLE_CYCLES+1 cycles before the CHECK sample.
- Timeline for `start` sampled at edge k:
  - APPLY of vector i is in cycle k+1+i·(2+SETTLE_CYCLES).
  - `done` is high in cycle k+1+NUM_VEC·(2+SETTLE_CYCLES), which is k+25 for the defaults.
- `start` is ignored in every state except IDLE, including the DONE cycle.
- `rst` mid-run: at the next edge return to IDLE with all outputs at reset values; no `done` pulse.
- The `err_count` update and the `fail_*` capture become visible the cycle after CHECK.

## Structure
- Package `alu_bist_pkg` holds:
  - opcode localparams OP_ADD…OP_SHR;
  - the FSM state enum;
  - a `bist_vec_t` struct (a, b, op, exp_result, exp_z);
  - the 8-entry vector ROM constant.
- One sub-module, `alu_bist_rom`: combinational index → `bist_vec_t` lookup.
- The FSM, counters and compare logic live in `alu_bist`.

## Test plan
- Connect the real ALU and pulse `start` → `done` at k+25, `pass`=1, `err_count`=0, `fail_valid`=0.
- Inject a fault: flip `alu_result` bit 0 while opcode=011 → `err_count`=1, `fail_valid`=1, `fail_index`=3, `pass`=0.
- Hold `alu_z` stuck at 0 → vectors 0 and 4 fail: `err_count`=2, `fail_index`=0, `pass`=0.
- Pulse `start` again during vector 2 and during the DONE cycle → no restart; exactly one `done` pulse at k+25.
- Assert `rst` for one cycle during vector 4 → next cycle IDLE, all outputs 0, no `done` pulse. A fresh `start` then completes normally with `pass`=1.
- SETTLE_CYCLES=3, NUM_VEC=8 → `done` at k+41. Operands are stable for 4 cycles before each CHECK; `pass`=1.
